// File: rtl/launch_queue_nw.sv
// In-order dual-lane launch queue between decode and issue: up to two
// enqueues and two dequeues per cycle, occupancy output and a sticky error flag.
module launch_queue_nw #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 256,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                flush_i,
    input  logic [1:0]          in_valid_i,
    input  logic [2*DATA_W-1:0] in_data_i,
    output logic                allowin_o,
    output logic [1:0]          out_valid_o,
    output logic [2*DATA_W-1:0] out_data_o,
    input  logic [1:0]          deq_cnt_i,
    output logic [PTR_W:0]      count_o,
    output logic                error_o
);

    localparam logic [PTR_W:0] ALLOW_MAX = (PTR_W+1)'(DEPTH - 2);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  head_p1;
    logic [PTR_W-1:0]  tail_p1;
    logic [PTR_W:0]    count;
    logic              error;
    logic [1:0]        n_enq;
    logic [1:0]        n_deq;
    logic              enq_err;
    logic              deq_err;

    assign head_p1   = head + PTR_W'(1);
    assign tail_p1   = tail + PTR_W'(1);
    assign allowin_o = (count <= ALLOW_MAX);

    // Flush swallows both sides of the cycle, including their error cases.
    always_comb begin
        n_enq   = 2'd0;
        n_deq   = 2'd0;
        enq_err = 1'b0;
        deq_err = 1'b0;
        if (!flush_i) begin
            if (in_valid_i == 2'b10 || (in_valid_i != 2'b00 && !allowin_o)) begin
                enq_err = 1'b1;
            end else if (in_valid_i == 2'b01) begin
                n_enq = 2'd1;
            end else if (in_valid_i == 2'b11) begin
                n_enq = 2'd2;
            end
            if (deq_cnt_i == 2'd3 || (PTR_W+1)'(deq_cnt_i) > count) begin
                deq_err = 1'b1;
            end else begin
                n_deq = deq_cnt_i;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            error <= 1'b0;
        end else begin
            if (flush_i) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                head  <= head + PTR_W'(n_deq);
                tail  <= tail + PTR_W'(n_enq);
                count <= count + (PTR_W+1)'(n_enq) - (PTR_W+1)'(n_deq);
            end
            if (enq_err || deq_err) begin
                error <= 1'b1;
            end
        end
    end

    // Payload storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (n_enq != 2'd0) begin
            mem[tail] <= in_data_i[DATA_W-1:0];
        end
        if (n_enq == 2'd2) begin
            mem[tail_p1] <= in_data_i[2*DATA_W-1:DATA_W];
        end
    end

    assign out_valid_o[0] = (count != '0);
    assign out_valid_o[1] = (count > (PTR_W+1)'(1));
    assign out_data_o     = {out_valid_o[1] ? mem[head_p1] : '0,
                             out_valid_o[0] ? mem[head]    : '0};
    assign count_o        = count;
    assign error_o        = error;

endmodule
